// File: rtl/sample_frame_reader.sv
// Streams overlapping FRAME_LEN-sample frames out of the circular sample RAM once
// the writer has committed enough samples, advancing the read base by HOP per frame.
module sample_frame_reader #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 10,
  parameter int FRAME_LEN = 256,
  parameter int HOP       = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              wr_pulse,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_first,
  output logic              m_last,
  output logic [ADDR_W:0]   fill_level,
  output logic              busy,
  output logic              overflow,
  input  logic              ovf_clr
);

  localparam logic [ADDR_W:0]   DEPTH_W  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   FRAME_W  = (ADDR_W+1)'(FRAME_LEN);
  localparam logic [ADDR_W:0]   HOP_W    = (ADDR_W+1)'(HOP);
  localparam logic [ADDR_W-1:0] HOP_ADV  = HOP_W[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, COMMIT} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] base, idx;
  logic [ADDR_W:0]   fill;
  logic              rd_pending, rd_first, rd_last;
  logic [1:0]        count;
  logic [DATA_W-1:0] head_data, tail_data;
  logic              head_first, head_last, tail_first, tail_last;
  logic              pop, push, room, issue, commit;

  assign pop    = (count != 2'd0) && m_ready;
  assign push   = rd_pending;
  assign commit = (state == COMMIT);
  // Room is judged after this cycle's pop so a ready sink sees one read per cycle.
  assign room   = ((count - {1'b0, pop}) + {1'b0, rd_pending}) < 2'd2;
  assign issue  = (state == STREAM) && room;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable && fill >= FRAME_W) state_next = STREAM;
      STREAM:  if (issue && idx == LAST_IDX) state_next = DRAIN;
      DRAIN:   if (pop && head_last) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ram_rd_en = issue;
    busy      = (state == STREAM) || (state == DRAIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base       <= '0;
      idx        <= '0;
      rd_pending <= 1'b0;
      rd_first   <= 1'b0;
      rd_last    <= 1'b0;
    end else begin
      if (state == IDLE) idx <= '0;
      else if (issue)    idx <= idx + 1'b1;
      if (commit) base <= base + HOP_ADV;
      rd_pending <= issue;
      rd_first   <= (idx == '0);
      rd_last    <= (idx == LAST_IDX);
    end
  end

  // A commit and a write in the same cycle both count; a write into a full RAM is an overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill     <= '0;
      overflow <= 1'b0;
    end else begin
      if (commit)                          fill <= fill + {{ADDR_W{1'b0}}, wr_pulse} - HOP_W;
      else if (wr_pulse && fill != DEPTH_W) fill <= fill + 1'b1;
      if (wr_pulse && !commit && fill == DEPTH_W) overflow <= 1'b1;
      else if (ovf_clr)                           overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= 2'd0;
      head_data  <= '0;
      head_first <= 1'b0;
      head_last  <= 1'b0;
      tail_data  <= '0;
      tail_first <= 1'b0;
      tail_last  <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            head_data <= ram_rd_data; head_first <= rd_first; head_last <= rd_last;
          end else begin
            tail_data <= ram_rd_data; tail_first <= rd_first; tail_last <= rd_last;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          head_data <= tail_data; head_first <= tail_first; head_last <= tail_last;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head_data <= ram_rd_data; head_first <= rd_first; head_last <= rd_last;
          end else begin
            head_data <= tail_data; head_first <= tail_first; head_last <= tail_last;
            tail_data <= ram_rd_data; tail_first <= rd_first; tail_last <= rd_last;
          end
        end
        default: ;
      endcase
    end
  end

  assign m_valid    = (count != 2'd0);
  assign m_data     = head_data;
  assign m_first    = head_first && m_valid;
  assign m_last     = head_last && m_valid;
  assign fill_level = fill;
  assign ram_rd_addr = base + idx;

endmodule

// File: tb/tb_sample_frame_reader.sv
// Bench for sample_frame_reader: a writer/RAM model feeds sample history, and each
// frame is compared against the absolute sample stream at frame_no*HOP.
module tb_sample_frame_reader;

  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 10;
  localparam int FRAME_LEN = 256;
  localparam int HOP       = 128;
  localparam int DEPTH     = 1 << ADDR_W;

  logic              clk, rst_n, enable, wr_pulse, ram_rd_en, m_valid, m_ready;
  logic              m_first, m_last, busy, overflow, ovf_clr;
  logic [ADDR_W-1:0] ram_rd_addr;
  logic [DATA_W-1:0] ram_rd_data, m_data;
  logic [ADDR_W:0]   fill_level;

  int checks, errors;
  int model_fill, frame_no, wr_ptr;
  bit model_ovf, rand_ready;
  logic [DATA_W-1:0] hist[$];
  logic [DATA_W-1:0] ram[DEPTH];

  logic [DATA_W-1:0] beat_data[$];
  logic              beat_first[$], beat_last[$];
  int                rd_addr_q[$], rd_cyc_q[$];
  int                cycle;
  logic              stall_prev;
  logic [DATA_W+1:0] stall_word;

  sample_frame_reader #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FRAME_LEN(FRAME_LEN), .HOP(HOP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .wr_pulse(wr_pulse),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_first(m_first),
    .m_last(m_last), .fill_level(fill_level), .busy(busy), .overflow(overflow),
    .ovf_clr(ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (ram_rd_en) ram_rd_data <= ram[ram_rd_addr];

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Downstream ready changes just after the active edge so the monitor sees settled values.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge clk) begin
    cycle++;
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        checkOutput("stall_hold", {m_valid, m_first, m_last, m_data}, {1'b1, stall_word});
      if (m_valid && m_ready) begin
        beat_data.push_back(m_data);
        beat_first.push_back(m_first);
        beat_last.push_back(m_last);
      end
      if (ram_rd_en) begin
        rd_addr_q.push_back(int'(ram_rd_addr));
        rd_cyc_q.push_back(cycle);
      end
      stall_prev = m_valid && !m_ready;
      stall_word = {m_first, m_last, m_data};
    end
  end

  task automatic resetModel();
    model_fill = 0;
    model_ovf  = 1'b0;
    frame_no   = 0;
    wr_ptr     = 0;
    hist.delete();
  endtask

  task automatic clearQueues();
    beat_data.delete();
    beat_first.delete();
    beat_last.delete();
    rd_addr_q.delete();
    rd_cyc_q.delete();
  endtask

  task automatic applyStimulus(input int n, input bit rnd_data, input bit gaps);
    logic [DATA_W-1:0] val;
    for (int i = 0; i < n; i++) begin
      val = rnd_data ? DATA_W'($urandom) : DATA_W'(wr_ptr);
      ram[wr_ptr % DEPTH] = val;
      hist.push_back(val);
      wr_ptr++;
      if (model_fill == DEPTH) model_ovf = 1'b1;
      else                     model_fill++;
      wr_pulse = 1'b1;
      @(negedge clk);
      if (gaps) begin
        wr_pulse = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
    wr_pulse = 1'b0;
  endtask

  task automatic waitFrame();
    int t = 0;
    while (beat_data.size() < FRAME_LEN && t < 4000) begin
      @(negedge clk);
      t++;
    end
    checkOutput("frame_timeout", {31'd0, t < 4000}, 32'd1);
    repeat (3) @(negedge clk);
    model_fill -= HOP;
  endtask

  task automatic checkFrame(input bit ready_always);
    int bad_data = 0, bad_flag = 0, bad_addr = 0;
    int nb = beat_data.size();
    int na = rd_addr_q.size();
    int base_exp = (frame_no * HOP) % DEPTH;
    for (int k = 0; k < FRAME_LEN; k++) begin
      if (k < nb) begin
        if (beat_data[k] !== hist[frame_no * HOP + k]) bad_data++;
        if (beat_first[k] !== (k == 0)) bad_flag++;
        if (beat_last[k] !== (k == FRAME_LEN - 1)) bad_flag++;
      end else begin
        bad_data++;
      end
      if (k >= na || rd_addr_q[k] != (base_exp + k) % DEPTH) bad_addr++;
    end
    checkOutput("beat_count", nb, FRAME_LEN);
    checkOutput("read_count", na, FRAME_LEN);
    checkOutput("frame_data_errs", bad_data, 0);
    checkOutput("frame_flag_errs", bad_flag, 0);
    checkOutput("frame_addr_errs", bad_addr, 0);
    checkOutput("fill_level", 32'(fill_level), model_fill);
    checkOutput("busy_after_frame", {31'd0, busy}, 32'd0);
    checkOutput("overflow", {31'd0, overflow}, {31'd0, model_ovf});
    if (ready_always && na == FRAME_LEN)
      checkOutput("read_burst_span", rd_cyc_q[na-1] - rd_cyc_q[0], FRAME_LEN - 1);
    frame_no++;
  endtask

  initial begin
    int t;
    checks = 0; errors = 0; cycle = 0;
    rst_n = 1'b0; enable = 1'b0; wr_pulse = 1'b0; ovf_clr = 1'b0; rand_ready = 1'b0;
    stall_prev = 1'b0; stall_word = '0;
    for (int i = 0; i < DEPTH; i++) ram[i] = '0;
    resetModel();
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_m_valid", {31'd0, m_valid}, 32'd0);
    checkOutput("rst_m_data", 32'(m_data), 32'd0);
    checkOutput("rst_m_first", {31'd0, m_first}, 32'd0);
    checkOutput("rst_m_last", {31'd0, m_last}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_fill", 32'(fill_level), 32'd0);
    checkOutput("rst_overflow", {31'd0, overflow}, 32'd0);
    checkOutput("rst_rd_en", {31'd0, ram_rd_en}, 32'd0);
    checkOutput("rst_rd_addr", 32'(ram_rd_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    enable = 1'b1;

    $display("[TB] frames 0 and 1 with ramp data");
    clearQueues(); applyStimulus(FRAME_LEN, 1'b0, 1'b0); waitFrame(); checkFrame(1'b1);
    clearQueues(); applyStimulus(HOP, 1'b0, 1'b0); waitFrame(); checkFrame(1'b1);

    $display("[TB] frames 2..6 with random data, gaps and ready");
    rand_ready = 1'b1;
    for (int f = 2; f <= 6; f++) begin
      clearQueues(); applyStimulus(HOP, 1'b1, 1'b1); waitFrame(); checkFrame(1'b0);
    end

    $display("[TB] frame 7 wraps the read address");
    rand_ready = 1'b0;
    repeat (2) @(negedge clk);
    clearQueues(); applyStimulus(HOP, 1'b1, 1'b0); waitFrame();
    checkOutput("wrap_addr_first", rd_addr_q.size() > 0 ? rd_addr_q[0] : -1, 896);
    checkOutput("wrap_addr_128", rd_addr_q.size() > 128 ? rd_addr_q[128] : -1, 0);
    checkFrame(1'b1);

    $display("[TB] reset mid-frame");
    clearQueues(); applyStimulus(HOP, 1'b1, 1'b0);
    t = 0;
    while (beat_data.size() < 20 && t < 2000) begin @(negedge clk); t++; end
    checkOutput("midframe_started", {31'd0, t < 2000}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_m_valid", {31'd0, m_valid}, 32'd0);
    checkOutput("async_rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("async_rst_fill", 32'(fill_level), 32'd0);
    checkOutput("async_rst_m_last", {31'd0, m_last}, 32'd0);
    resetModel();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] commit coinciding with a write at fill 300");
    enable = 1'b0;
    clearQueues(); applyStimulus(300, 1'b1, 1'b0);
    checkOutput("fill_300", 32'(fill_level), model_fill);
    enable = 1'b1;
    t = 0;
    while (!busy && t < 100) begin @(negedge clk); t++; end
    while (busy && t < 4000) begin @(negedge clk); t++; end
    checkOutput("commit_seen", {31'd0, t < 4000}, 32'd1);
    applyStimulus(1, 1'b1, 1'b0);
    model_fill -= HOP;
    checkOutput("commit_wr_fill", 32'(fill_level), model_fill);
    checkFrame(1'b1);

    $display("[TB] saturation and overflow");
    rst_n = 1'b0;
    @(negedge clk);
    resetModel();
    rst_n = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    applyStimulus(DEPTH, 1'b0, 1'b0);
    checkOutput("fill_full", 32'(fill_level), model_fill);
    checkOutput("no_ovf_at_full", {31'd0, overflow}, {31'd0, model_ovf});
    applyStimulus(1, 1'b0, 1'b0);
    checkOutput("fill_saturated", 32'(fill_level), model_fill);
    checkOutput("ovf_set", {31'd0, overflow}, {31'd0, model_ovf});
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    model_ovf = 1'b0;
    checkOutput("ovf_cleared", {31'd0, overflow}, {31'd0, model_ovf});
    ovf_clr = 1'b1;
    applyStimulus(1, 1'b0, 1'b0);
    ovf_clr = 1'b0;
    checkOutput("ovf_set_beats_clr", {31'd0, overflow}, {31'd0, model_ovf});
    checkOutput("fill_still_full", 32'(fill_level), model_fill);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
